// File: rtl/lfsr_seq_checker_if.sv
// Purpose : received LFSR word stream plus checker status, bundled for lfsr_seq_checker.
// Latency : n/a (signal bundle only).
// Backpressure: none; the stream is valid-only and the checker accepts every valid word.
//
// Ports (signals):
//   in_valid, in_data      - received word stream (driven by the source / master)
//   locked, state          - checker lock status (driven by the checker / slave)
//   err_pulse, err_cnt,
//   word_cnt               - error reporting and statistics (driven by the checker)
interface lfsr_seq_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             locked;
  logic [1:0]       state;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output in_valid, in_data,
    input  locked, state, err_pulse, err_cnt, word_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output locked, state, err_pulse, err_cnt, word_cnt
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Purpose : self-synchronising receive checker for a Galois LFSR word stream; counts mismatches once locked.
// Latency : all outputs registered, updated on the clk edge that samples in_valid=1.
// Backpressure: none; every valid word is consumed in the cycle it is presented.
//
// Ports:
//   clk, rst_n (sync, active-low), clr (sync clear, same effect as reset, wins over in_valid)
//   rx : lfsr_seq_checker_if.slave - in_valid/in_data in; locked/state/err_pulse/err_cnt/word_cnt out
//   state encoding: 0=SEARCH, 1=SYNC, 2=LOCKED
//
// Optional feature macro: LFSR_CHK_RESEED_EN
//   undefined : a mismatch while locked advances the expected value from the prediction (flywheel)
//   defined   : a nonzero mismatch while locked reseeds the prediction from the received word
module lfsr_seq_checker #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [63:0] TAPS     = 64'hB8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  lfsr_seq_checker_if.slave rx
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam int unsigned      MR_W     = $clog2(LOCK_CNT + 1);
  localparam int unsigned      MS_W     = $clog2(MISS_MAX + 1);
  localparam logic [MR_W-1:0]  LOCK_TGT = MR_W'(LOCK_CNT);
  localparam logic [MS_W-1:0]  MISS_TGT = MS_W'(MISS_MAX);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Must stay bit-identical to the generator's step.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ TAP_MASK) : (s >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  chk_state_t       st_q,    st_d;
  logic [WIDTH-1:0] exp_q,   exp_d;
  logic [MR_W-1:0]  mrun_q,  mrun_d;
  logic [MS_W-1:0]  miss_q,  miss_d;
  logic [CNT_W-1:0] err_q,   err_d;
  logic [CNT_W-1:0] word_q,  word_d;
  logic             pulse_q, pulse_d;

  logic in_zero;
  logic in_hit;

  // Zero is the LFSR lock-up state and never appears in a valid stream.
  assign in_zero = (rx.in_data == '0);
  assign in_hit  = (rx.in_data == exp_q);

  always_comb begin
    st_d    = st_q;
    exp_d   = exp_q;
    mrun_d  = mrun_q;
    miss_d  = miss_q;
    err_d   = err_q;
    word_d  = word_q;
    pulse_d = 1'b0;

    if (rx.in_valid) begin
      case (st_q)
        SEARCH: begin
          if (!in_zero) begin
            exp_d  = lfsr_step(rx.in_data);
            mrun_d = '0;
            st_d   = SYNC;
          end
        end

        SYNC: begin
          if (in_zero) begin
            mrun_d = '0;
            st_d   = SEARCH;
          end else if (in_hit) begin
            exp_d = lfsr_step(exp_q);
            if (mrun_q + MR_W'(1) == LOCK_TGT) begin
              mrun_d = '0;
              miss_d = '0;
              st_d   = LOCKED;
            end else begin
              mrun_d = mrun_q + MR_W'(1);
            end
          end else begin
            // Treat the mismatching word as a fresh seed candidate.
            exp_d  = lfsr_step(rx.in_data);
            mrun_d = '0;
          end
        end

        LOCKED: begin
          word_d = sat_inc(word_q);
          if (in_hit) begin
            miss_d = '0;
            exp_d  = lfsr_step(exp_q);
          end else begin
            err_d   = sat_inc(err_q);
            pulse_d = 1'b1;
`ifdef LFSR_CHK_RESEED_EN
            exp_d   = in_zero ? lfsr_step(exp_q) : lfsr_step(rx.in_data);
`else
            exp_d   = lfsr_step(exp_q);
`endif
            if (miss_q + MS_W'(1) == MISS_TGT) begin
              miss_d = '0;
              st_d   = SEARCH;
            end else begin
              miss_d = miss_q + MS_W'(1);
            end
          end
        end

        default: begin
          st_d   = SEARCH;
          mrun_d = '0;
          miss_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      st_q    <= SEARCH;
      exp_q   <= '0;
      mrun_q  <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      word_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      exp_q   <= exp_d;
      mrun_q  <= mrun_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      word_q  <= word_d;
      pulse_q <= pulse_d;
    end
  end

  assign rx.state     = st_q;
  assign rx.locked    = (st_q == LOCKED);
  assign rx.err_pulse = pulse_q;
  assign rx.err_cnt   = err_q;
  assign rx.word_cnt  = word_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Purpose : randomized + directed bench for lfsr_seq_checker against a sequence-position reference model.
// Latency : checks every output one cycle after each driven edge.
// Backpressure: n/a.
module tb_lfsr_seq_checker;

`ifdef LFSR_CHK_RESEED_EN
  localparam bit RESEED = 1'b1;
`else
  localparam bit RESEED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic clr_a;
  logic clr_b;

  lfsr_seq_checker_if #(.WIDTH(8), .CNT_W(16)) ifa ();
  lfsr_seq_checker_if #(.WIDTH(8), .CNT_W(4))  ifb ();

  lfsr_seq_checker #(.WIDTH(8), .TAPS(64'hB8), .LOCK_CNT(4), .MISS_MAX(4), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_a),
    .rx    (ifa.slave)
  );

  lfsr_seq_checker #(.WIDTH(8), .TAPS(64'hB8), .LOCK_CNT(4), .MISS_MAX(32), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_b),
    .rx    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // The model tracks the stream as positions in one full period of the sequence.
  int seq [256];
  int idx [256];
  int period;

  function automatic int nxt(input int v);
    return seq[(idx[v] + 1) % period];
  endfunction

  typedef struct {
    int mode;   // 0 search, 1 sync, 2 locked
    int expv;
    int mrun;
    int miss;
    int err;
    int word;
    bit pulse;
  } model_t;

  model_t m [2];

  function automatic model_t model_reset();
    model_t r;
    r.mode = 0; r.expv = 0; r.mrun = 0; r.miss = 0;
    r.err = 0; r.word = 0; r.pulse = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t s, input bit vld, input int d,
                                        input bit c, input int w);
    model_t r;
    int miss_max;
    int cmax;
    miss_max = (w == 0) ? 4 : 32;
    cmax     = (w == 0) ? 65535 : 15;
    r = s;
    if (c) return model_reset();
    r.pulse = 1'b0;
    if (!vld) return r;
    if (s.mode == 0) begin
      if (d != 0) begin
        r.expv = nxt(d); r.mrun = 0; r.mode = 1;
      end
    end else if (s.mode == 1) begin
      if (d == 0) begin
        r.mode = 0;
      end else if (d == s.expv) begin
        r.mrun = s.mrun + 1;
        r.expv = nxt(s.expv);
        if (r.mrun == 4) begin
          r.mode = 2; r.miss = 0;
        end
      end else begin
        r.expv = nxt(d); r.mrun = 0;
      end
    end else begin
      r.word = (s.word < cmax) ? s.word + 1 : cmax;
      if (d == s.expv) begin
        r.miss = 0;
        r.expv = nxt(s.expv);
      end else begin
        r.err   = (s.err < cmax) ? s.err + 1 : cmax;
        r.pulse = 1'b1;
        r.expv  = (RESEED && d != 0) ? nxt(d) : nxt(s.expv);
        r.miss  = s.miss + 1;
        if (r.miss == miss_max) begin
          r.mode = 0; r.miss = 0;
        end
      end
    end
    return r;
  endfunction

  task automatic cmp_all();
    chk("a_state",  ifa.state,     m[0].mode);
    chk("a_locked", ifa.locked,    m[0].mode == 2);
    chk("a_pulse",  ifa.err_pulse, m[0].pulse);
    chk("a_err",    ifa.err_cnt,   m[0].err);
    chk("a_word",   ifa.word_cnt,  m[0].word);
    chk("b_state",  ifb.state,     m[1].mode);
    chk("b_locked", ifb.locked,    m[1].mode == 2);
    chk("b_pulse",  ifb.err_pulse, m[1].pulse);
    chk("b_err",    ifb.err_cnt,   m[1].err);
    chk("b_word",   ifb.word_cnt,  m[1].word);
  endtask

  // One clock with stimulus on DUT w; the other DUT idles.
  task automatic cyc(input int w, input bit vld, input int d, input bit c);
    ifa.in_valid = (w == 0) ? vld : 1'b0;
    ifa.in_data  = (w == 0) ? 8'(d) : 8'h00;
    clr_a        = (w == 0) ? c : 1'b0;
    ifb.in_valid = (w == 1) ? vld : 1'b0;
    ifb.in_data  = (w == 1) ? 8'(d) : 8'h00;
    clr_b        = (w == 1) ? c : 1'b0;
    @(posedge clk);
    #1;
    m[0] = model_step(m[0], ifa.in_valid, int'(ifa.in_data), clr_a, 0);
    m[1] = model_step(m[1], ifb.in_valid, int'(ifb.in_data), clr_b, 1);
    cmp_all();
  endtask

  initial begin
    int v;
    int p;
    int r;
    int err_before;

    for (int i = 0; i < 256; i++) idx[i] = -1;
    v = 1;
    period = 0;
    do begin
      seq[period] = v;
      idx[v] = period;
      period++;
      v = (v % 2 == 1) ? ((v / 2) ^ 'hB8) : (v / 2);
    end while (v != 1 && period < 256);

    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    m[0] = model_reset();
    m[1] = model_reset();
    cmp_all();
    chk("rst_state", ifa.state, 0);
    chk("rst_err", ifa.err_cnt, 0);
    rst_n = 1'b1;

    // Lock on 01,B8,5C,2E,17
    cyc(0, 1, 'h01, 0);
    chk("lock_sync", ifa.state, 1);
    for (int i = 1; i < 5; i++) cyc(0, 1, seq[i], 0);
    chk("lock_locked", ifa.locked, 1);
    chk("lock_word", ifa.word_cnt, 0);

    // Clean run with a gap
    cyc(0, 1, 'hB3, 0);
    repeat (3) cyc(0, 0, 'h5A, 0);
    cyc(0, 1, 'hE1, 0);
    cyc(0, 1, 'hC8, 0);
    chk("clean_word", ifa.word_cnt, 3);
    chk("clean_err", ifa.err_cnt, 0);

    // Single corrupted word in place of 64, then 32
    cyc(0, 1, 'hFF, 0);
    chk("single_pulse", ifa.err_pulse, 1);
    chk("single_err", ifa.err_cnt, 1);
    cyc(0, 1, 'h32, 0);
    chk("single_after", ifa.err_cnt, RESEED ? 2 : 1);
    cyc(0, 1, 'h19, 0);
    chk("single_locked", ifa.locked, 1);

    // Loss of lock on four zero words
    repeat (3) cyc(0, 1, 0, 0);
    chk("loss_still", ifa.locked, 1);
    cyc(0, 1, 0, 0);
    chk("loss_state", ifa.state, 0);
    chk("loss_err", ifa.err_cnt, RESEED ? 6 : 5);
    err_before = int'(ifa.err_cnt);

    // SEARCH/SYNC robustness
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rob_zero", ifa.state, 0);
    cyc(0, 1, 'h55, 0);
    chk("rob_sync", ifa.state, 1);
    cyc(0, 1, 'h12, 0);
    chk("rob_reseed", ifa.state, 1);
    chk("rob_err", ifa.err_cnt, err_before);
    cyc(0, 1, 0, 0);

    // Relock, counters retained
    for (int i = 0; i < 5; i++) cyc(0, 1, seq[i], 0);
    chk("relock", ifa.locked, 1);
    chk("relock_err", ifa.err_cnt, err_before);

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) cyc(1, 1, seq[i], 0);
    repeat (20) cyc(1, 1, 0, 0);
    chk("sat_err", ifb.err_cnt, 15);
    chk("sat_word", ifb.word_cnt, 15);
    chk("sat_locked", ifb.locked, 1);
    cyc(1, 1, seq[5], 1);
    chk("clr_state", ifb.state, 0);
    chk("clr_err", ifb.err_cnt, 0);
    chk("clr_word", ifb.word_cnt, 0);

    // Randomized stream with corruption, drops, zeros, bursts and clears
    p = $urandom_range(0, period - 1);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        cyc(0, 0, $urandom_range(0, 255), 0);
      end else if (r < 21) begin
        cyc(0, 1, $urandom_range(0, 255), 0);
        p = (p + 1) % period;
      end else if (r < 24) begin
        p = (p + 1) % period;
        cyc(0, 1, seq[p], 0);
        p = (p + 1) % period;
      end else if (r < 26) begin
        cyc(0, 1, 0, 0);
      end else if (r < 27) begin
        repeat (5) cyc(0, 1, 0, 0);
      end else if (r == 27) begin
        cyc(0, 1, seq[p], 1);
        p = (p + 1) % period;
      end else begin
        cyc(0, 1, seq[p], 0);
        p = (p + 1) % period;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
